// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write scoreboard for decode hazard stalls.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 8,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(NREGS)-1:0] wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  output logic [XLEN-1:0]          rs1_data,
  output logic                     rs1_busy,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs2_data,
  output logic                     rs2_busy,
  input  logic                     issue_en,
  input  logic [$clog2(NREGS)-1:0] issue_rd,
  input  logic                     flush,
  output logic [$clog2(NREGS):0]   pend_cnt
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = AW + 1;
  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0]  mem [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] pend_next;
  logic [CW-1:0]    cnt_next;

  logic wr_ok;
  logic iss_ok;
  logic cnt_inc;
  logic cnt_dec;

  // Register 0 swallows writes and issues when it is hardwired to zero.
  assign wr_ok  = wr_en && !(ZR && (wr_addr == '0));
  assign iss_ok = issue_en && !flush && !(ZR && (issue_rd == '0));

  always_comb begin
    pend_next = pending;
    if (flush) begin
      pend_next = '0;
    end else begin
      if (wr_ok)  pend_next[wr_addr]  = 1'b0;
      if (iss_ok) pend_next[issue_rd] = 1'b1;
    end
  end

  // Only the issue bit can rise and only the write bit can fall, so the count
  // moves by the net of those two transitions.
  always_comb begin
    cnt_inc = iss_ok && !pending[issue_rd];
    cnt_dec = wr_ok && pending[wr_addr] && !(iss_ok && (issue_rd == wr_addr));
    cnt_next = pend_cnt;
    if (flush) begin
      cnt_next = '0;
    end else begin
      case ({cnt_inc, cnt_dec})
        2'b10:   cnt_next = pend_cnt + CW'(1);
        2'b01:   cnt_next = pend_cnt - CW'(1);
        default: cnt_next = pend_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      pending  <= pend_next;
      pend_cnt <= cnt_next;
    end
  end

  always_comb begin
    rs1_data = mem[rs1_addr];
    rs1_busy = pending[rs1_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (wr_addr == rs1_addr)) begin
      rs1_data = wr_data;
      rs1_busy = 1'b0;
    end
`endif
    if (ZR && (rs1_addr == '0)) begin
      rs1_data = '0;
      rs1_busy = 1'b0;
    end
  end

  always_comb begin
    rs2_data = mem[rs2_addr];
    rs2_busy = pending[rs2_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_ok && (wr_addr == rs2_addr)) begin
      rs2_data = wr_data;
      rs2_busy = 1'b0;
    end
`endif
    if (ZR && (rs2_addr == '0)) begin
      rs2_data = '0;
      rs2_busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed table, hand-written corner sequences, random run
// against a behavioural model, plus a 64-bit/32-register instance with ZERO_REG=0.
module tb_regfile_sb;

  localparam int X  = 32;
  localparam int N  = 8;
  localparam int A  = 3;
  localparam int PX = 64;
  localparam int PN = 32;
  localparam int PA = 5;

  logic clk = 1'b0;
  logic rst_n;

  logic         wr_en, issue_en, flush;
  logic [A-1:0] wr_addr, issue_rd, rs1_addr, rs2_addr;
  logic [X-1:0] wr_data, rs1_data, rs2_data;
  logic         rs1_busy, rs2_busy;
  logic [A:0]   pend_cnt;

  logic          p_wr_en, p_issue_en, p_flush;
  logic [PA-1:0] p_wr_addr, p_issue_rd, p_rs1_addr, p_rs2_addr;
  logic [PX-1:0] p_wr_data, p_rs1_data, p_rs2_data;
  logic          p_rs1_busy, p_rs2_busy;
  logic [PA:0]   p_pend_cnt;

  int tests = 0;
  int fails = 0;
  logic [X-1:0] exp_q[$];

  regfile_sb #(.XLEN(X), .NREGS(N), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs1_busy(rs1_busy),
    .rs2_addr(rs2_addr), .rs2_data(rs2_data), .rs2_busy(rs2_busy),
    .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush), .pend_cnt(pend_cnt)
  );

  regfile_sb #(.XLEN(PX), .NREGS(PN), .ZERO_REG(0)) dut_p (
    .clk(clk), .rst_n(rst_n), .wr_en(p_wr_en), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .rs1_addr(p_rs1_addr), .rs1_data(p_rs1_data), .rs1_busy(p_rs1_busy),
    .rs2_addr(p_rs2_addr), .rs2_data(p_rs2_data), .rs2_busy(p_rs2_busy),
    .issue_en(p_issue_en), .issue_rd(p_issue_rd), .flush(p_flush), .pend_cnt(p_pend_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [X-1:0] m_reg [N];
  bit           m_pend[N];

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  function automatic logic [X-1:0] m_read(input int a, input bit we, input int wa, input logic [X-1:0] wd);
    if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == a) return wd;
`endif
    return m_reg[a];
  endfunction

  function automatic bit m_busy(input int a, input bit we, input int wa);
    if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (we && wa == a) return 1'b0;
`endif
    return m_pend[a];
  endfunction

  function automatic void m_update(input bit we, input int wa, input logic [X-1:0] wd,
                                   input bit ie, input int ir, input bit fl);
    if (we && wa != 0) m_reg[wa] = wd;
    if (fl) begin
      for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    end else begin
      if (we && wa != 0) m_pend[wa] = 1'b0;
      if (ie && ir != 0) m_pend[ir] = 1'b1;
    end
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_strobes();
    wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
  endtask

  task automatic apply(input bit we, input int wa, input logic [X-1:0] wd,
                       input bit ie, input int ir, input bit fl, input int a1, input int a2);
    @(negedge clk);
    wr_en = we; wr_addr = A'(wa); wr_data = wd;
    issue_en = ie; issue_rd = A'(ir); flush = fl;
    rs1_addr = A'(a1); rs2_addr = A'(a2);
    @(posedge clk);
    m_update(we, wa, wd, ie, ir, fl);
    #1 clear_strobes();
    #1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit we; int wa; logic [X-1:0] wd; bit ie; int ir; bit fl; int a1; int a2;
    logic [X-1:0] d1; bit b1; logic [X-1:0] d2; bit b2; int pc;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{0, 0, 32'h0,        1, 2, 0, 2, 3, 32'h0,        1, 32'h0,  0, 1};
    vt[1] = '{0, 0, 32'h0,        1, 3, 0, 2, 3, 32'h0,        1, 32'h0,  1, 2};
    vt[2] = '{0, 0, 32'h0,        1, 4, 0, 2, 4, 32'h0,        1, 32'h0,  1, 3};
    vt[3] = '{1, 3, 32'h55,       0, 0, 0, 2, 3, 32'h0,        1, 32'h55, 0, 2};
    vt[4] = '{1, 4, 32'h66,       0, 0, 0, 2, 4, 32'h0,        1, 32'h66, 0, 1};
    vt[5] = '{0, 0, 32'h0,        1, 6, 0, 2, 6, 32'h0,        1, 32'h0,  1, 2};
    vt[6] = '{1, 6, 32'h11,       1, 6, 0, 6, 2, 32'h11,       1, 32'h0,  1, 2};
    vt[7] = '{0, 0, 32'h0,        1, 7, 1, 7, 6, 32'h0,        0, 32'h11, 0, 0};
    vt[8] = '{1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 3, 32'h0,        0, 32'h55, 0, 0};
    vt[9] = '{1, 3, 32'hDEADBEEF, 1, 5, 0, 3, 5, 32'hDEADBEEF, 0, 32'h0,  1, 1};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    clear_strobes();
    wr_addr = '0; wr_data = '0; issue_rd = '0; rs1_addr = '0; rs2_addr = '0;
    p_wr_en = 1'b0; p_issue_en = 1'b0; p_flush = 1'b0;
    p_wr_addr = '0; p_wr_data = '0; p_issue_rd = '0; p_rs1_addr = '0; p_rs2_addr = '0;
    m_reset();
    #1;
    chk("reset_rs1_data", rs1_data, 0);
    chk("reset_rs1_busy", rs1_busy, 0);
    chk("reset_pend_cnt", pend_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      apply(vt[i].we, vt[i].wa, vt[i].wd, vt[i].ie, vt[i].ir, vt[i].fl, vt[i].a1, vt[i].a2);
      chk($sformatf("vec%0d_rs1_data", i), rs1_data, vt[i].d1);
      chk($sformatf("vec%0d_rs1_busy", i), rs1_busy, vt[i].b1);
      chk($sformatf("vec%0d_rs2_data", i), rs2_data, vt[i].d2);
      chk($sformatf("vec%0d_rs2_busy", i), rs2_busy, vt[i].b2);
      chk($sformatf("vec%0d_pend_cnt", i), pend_cnt, vt[i].pc);
    end

    // asynchronous reset between edges, with reg3 written and reg5 pending
    @(negedge clk);
    rs1_addr = 3'd3; rs2_addr = 3'd5;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rs1_data", rs1_data, 0);
    chk("async_rst_rs2_busy", rs2_busy, 0);
    chk("async_rst_pend_cnt", pend_cnt, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(0, 0, 0, 1, 2, 0, 2, 3);
    chk("post_rst_busy", rs1_busy, 1);
    chk("post_rst_pend_cnt", pend_cnt, 1);

    // write to a pending register while it is being read
    apply(0, 0, 0, 1, 1, 0, 2, 1);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'hA5A5A5A5; rs2_addr = 3'd1;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle_data", rs2_data, 32'hA5A5A5A5);
    chk("bypass_same_cycle_busy", rs2_busy, 0);
`else
    chk("nobypass_before_data", rs2_data, 32'h0);
    chk("nobypass_before_busy", rs2_busy, 1);
`endif
    @(posedge clk);
    m_update(1, 1, 32'hA5A5A5A5, 0, 0, 0);
    #1 clear_strobes();
    #1;
    chk("after_write_data", rs2_data, 32'hA5A5A5A5);
    chk("after_write_busy", rs2_busy, 0);
    chk("after_write_pend_cnt", pend_cnt, 1);

    // random run against the model
    for (int i = 0; i < 300; i++) begin
      bit we, ie, fl;
      int wa, ir, a1, a2;
      logic [X-1:0] wd;
      @(negedge clk);
      we = 1'($urandom_range(0, 1)); wa = $urandom_range(0, N-1); wd = $urandom;
      ie = 1'($urandom_range(0, 1)); ir = $urandom_range(0, N-1);
      fl = ($urandom_range(0, 15) == 0);
      a1 = $urandom_range(0, N-1);
      a2 = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, N-1);
      wr_en = we; wr_addr = A'(wa); wr_data = wd;
      issue_en = ie; issue_rd = A'(ir); flush = fl;
      rs1_addr = A'(a1); rs2_addr = A'(a2);
      exp_q.push_back(m_read(a1, we, wa, wd));
      exp_q.push_back(m_read(a2, we, wa, wd));
      #1;
      chk("rand_rs1_data", rs1_data, exp_q.pop_front());
      chk("rand_rs2_data", rs2_data, exp_q.pop_front());
      chk("rand_rs1_busy", rs1_busy, m_busy(a1, we, wa));
      chk("rand_rs2_busy", rs2_busy, m_busy(a2, we, wa));
      chk("rand_pend_cnt", pend_cnt, m_count());
      @(posedge clk);
      m_update(we, wa, wd, ie, ir, fl);
    end
    @(negedge clk);
    clear_strobes();

    // wide instance: register 0 is ordinary
    @(negedge clk);
    p_wr_en = 1'b1; p_wr_addr = 5'd31; p_wr_data = 64'h0123456789ABCDEF;
    @(posedge clk);
    #1 p_wr_en = 1'b0; p_rs1_addr = 5'd31;
    #1 chk("p_reg31_data", p_rs1_data, 64'h0123456789ABCDEF);
    @(negedge clk);
    p_wr_en = 1'b1; p_wr_addr = 5'd0; p_wr_data = 64'hFEDC000000000077;
    @(posedge clk);
    #1 p_wr_en = 1'b0; p_rs2_addr = 5'd0;
    #1 chk("p_reg0_data", p_rs2_data, 64'hFEDC000000000077);
    for (int i = 0; i < PN; i++) begin
      @(negedge clk);
      p_issue_en = 1'b1; p_issue_rd = PA'(i);
      @(posedge clk);
      #1 p_issue_en = 1'b0;
    end
    #1;
    chk("p_pend_cnt_full", p_pend_cnt, 32);
    chk("p_reg0_busy", p_rs2_busy, 1);
    chk("p_reg31_busy", p_rs1_busy, 1);
    @(negedge clk);
    p_flush = 1'b1;
    @(posedge clk);
    #1 p_flush = 1'b0;
    #1;
    chk("p_pend_cnt_flush", p_pend_cnt, 0);
    chk("p_reg31_busy_flush", p_rs1_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file for the RISC-V core with an integrated per-register scoreboard. It provides two combinational read ports and one synchronous write port, an optional hardwired-zero register, and optional write-to-read bypass. Pending-write tracking (issue sets, writeback clears, flush clears all) gives the decode stage per-operand busy flags and a live pending count for hazard stalls. It sits between decode (reads and issue) and writeback (writes).

## Interface
- XLEN, 32, data width of every register
- NREGS, 8, number of registers; power of two, 2 to 64; AW = $clog2(NREGS) (localparam)
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and is never pending; 0 = register 0 is ordinary
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  writeback strobe
- wr_addr  input  AW  writeback destination
- wr_data  input  XLEN  writeback value
- rs1_addr  input  AW  read port 1 address
- rs1_data  output  XLEN  read port 1 value (combinational)
- rs1_busy  output  1  rs1_addr has a pending write
- rs2_addr  input  AW  read port 2 address
- rs2_data  output  XLEN  read port 2 value (combinational)
- rs2_busy  output  1  rs2_addr has a pending write
- issue_en  input  1  an instruction writing issue_rd was issued
- issue_rd  input  AW  destination of the issued instruction
- flush  input  1  synchronous clear of all pending bits
- pend_cnt  output  AW+1  number of registers currently pending (registered)

## Operation
- Storage: NREGS x XLEN array plus an NREGS-bit pending vector.
- Write: on a rising edge with wr_en, reg[wr_addr] <= wr_data. The pending bit of wr_addr clears. Writes to a register that is not pending are legal and leave pend_cnt unchanged.
- Issue: on a rising edge with issue_en, pending[issue_rd] <= 1.
- Same-register issue and write in one cycle: the data is written, the pending bit ends set (the new producer wins), and pend_cnt is unchanged.
- Flush: on a rising edge with flush, all pending bits clear and pend_cnt <= 0. Issue in the same cycle is ignored. A write in the same cycle still updates data.
- ZERO_REG=1: wr_en with wr_addr=0 is dropped; issue_en with issue_rd=0 is dropped; reads of 0 return 0 with busy=0.
- pend_cnt is always equal to the popcount of the pending vector. It is updated each edge by +1 (bit newly set), -1 (bit newly cleared), or 0 when both or neither happen. Issue and write to different registers in one edge give a net 0.
- rsN_busy = pending[rsN_addr], subject to the bypass rule in Configuration.

## Timing
- Reset (rst_n low, asynchronous): all registers 0, pending vector 0, pend_cnt 0. rs1_data, rs2_data, rs1_busy and rs2_busy therefore read 0.
- Reset deasserted mid-operation: there is no residual state, and the first edge after release behaves normally.
- Read latency is 0 cycles from address, and from the write when bypass is enabled.
- Write-to-visible latency without bypass is 1 edge.
- Issue-to-busy latency is 1 edge. Busy is never asserted in the same cycle as issue.
- No backpressure: every strobe is accepted on the edge where it is high.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If wr_en is high and rsN_addr == wr_addr (and not the zero register), rsN_data = wr_data and rsN_busy = 0 in that same cycle.
  - This holds even if issue to the same register is also occurring.
- REGFILE_BYPASS_EN undefined:
  - rsN_data is the stored value and rsN_busy is the registered pending bit.
  - The written value appears one edge later.

## Test plan
- Reset: assert rst_n=0 mid-run after writing reg3=0xDEADBEEF and issuing reg5. Required: rs1_data(addr 3)=0, rs2_busy(addr 5)=0, pend_cnt=0 immediately, without waiting for a clock edge.
- Scoreboard: issue 2, 3 and 4 on consecutive edges, giving pend_cnt=1, 2, 3. Then write reg3=0x55 and reg4=0x66, giving pend_cnt=2, then 1. rs1_busy(2)=1 throughout.
- Collision and flush:
  - Issue reg6 and write reg6=0x11 on the same edge. Required: reg6=0x11, busy(6)=1, pend_cnt unchanged.
  - Then flush together with issue reg7. Required: pend_cnt=0 and busy(7)=0.
- Zero register (ZERO_REG=1): write reg0=0xFFFFFFFF and issue reg0. Required: rs1_data(0)=0, rs1_busy(0)=0, pend_cnt=0.
- Bypass, with REGFILE_BYPASS_EN defined:
  - Issue reg1, then in a later cycle drive wr_en with reg1=0xA5A5A5A5 while rs2_addr=1.
  - Required in that same cycle: rs2_data=0xA5A5A5A5 and rs2_busy=0.
- Bypass, with REGFILE_BYPASS_EN undefined: repeat the previous stimulus. Required: the old value and rs2_busy=1 before the edge, then 0xA5A5A5A5 and busy=0 after it.
- Parametrisation: run with XLEN=64, NREGS=32 and ZERO_REG=0. Write reg31=0x0123456789ABCDEF and read it back. Issue all 32 registers, giving pend_cnt=32; flush, giving pend_cnt=0.
